// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the dmem_responder slice
// Contents: FSM state enum, data width, default DEPTH / WAIT_CYCLES.
package dmem_pkg;

    localparam int DATA_W              = 32;
    localparam int DEFAULT_DEPTH       = 64;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array, synchronous write, combinational read, reset clear
// Optional feature macro: DMEM_PARITY_EN (adds one stored parity bit per word).
// Ports:
//   clk, reset     clock, synchronous active-high clear of every word
//   we             write enable, word written on rising edge
//   waddr, wdata   write word index and data
//   raddr, rdata   read word index and combinational read data
//   wpar, rpar     (DMEM_PARITY_EN only) parity bit written / read alongside data
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
`ifdef DMEM_PARITY_EN
    ,
    input  logic                     wpar,
    output logic                     rpar
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

`ifdef DMEM_PARITY_EN
    logic [DEPTH-1:0] par;

    always_ff @(posedge clk) begin
        if (reset) begin
            par <= '0;
        end else if (we) begin
            par[waddr] <= wpar;
        end
    end

    assign rpar = par[raddr];
`endif

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder (IDLE/WAIT/RESP)
// Optional feature macro: DMEM_PARITY_EN (adds parity_err output and per-word parity).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mem_rd, mem_wr    read / write request, held until ready
//   addr, wr_data     byte address and write data, latched at capture
//   rd_data           read data; holds last read result (0 after an error)
//   ready             one-cycle completion strobe
//   addr_err          qualifies ready: request rejected
//   parity_err        (DMEM_PARITY_EN only) qualifies ready: stored parity mismatch
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              addr_err
`ifdef DMEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              capture;

    logic [DATA_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_rd;
    logic              cap_wr;

    logic [AW-1:0]     cap_idx;
    logic              cap_err;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] rd_hold;

    // Decode works only on the latched request, so the requester may change
    // its inputs freely once captured.
    assign cap_idx = cap_addr[AW+1:2];
    assign cap_err = (cap_addr[1:0] != 2'b00)
                   || (cap_addr[DATA_W-1:AW+2] != '0)
                   || (cap_rd && cap_wr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
            rd_hold   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                cap_addr  <= addr;
                cap_wdata <= wr_data;
                cap_rd    <= mem_rd;
                cap_wr    <= mem_wr;
            end
            // Reads and errors replace the held value; writes leave it alone.
            if (ready && (cap_err || cap_rd)) begin
                rd_hold <= rd_data;
            end
        end
    end

    // RESP always falls back to IDLE, and IDLE only captures on the following
    // edge; that bubble keeps a request still held during RESP from being
    // served twice.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_rd || mem_wr) begin
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'(WAIT_CYCLES - 1)) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset in RESP suppresses the strobe in that same cycle so an abandoned
    // request never shows a completion.
    always_comb begin
        ready    = (state == RESP) && !reset;
        addr_err = ready && cap_err;
        arr_we   = ready && cap_wr && !cap_err;
        rd_data  = rd_hold;
        if (ready) begin
            if (cap_err) begin
                rd_data = '0;
            end else if (cap_rd) begin
                rd_data = arr_rdata;
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic arr_rpar;

    // Even parity: stored bit equals XOR of the data, so data plus bit has
    // an even number of ones.
    assign parity_err = ready && !cap_err && cap_rd && (arr_rpar != ^arr_rdata);
`endif

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .waddr (cap_idx),
        .wdata (cap_wdata),
        .raddr (cap_idx),
        .rdata (arr_rdata)
`ifdef DMEM_PARITY_EN
        ,
        .wpar  (^cap_wdata),
        .rpar  (arr_rpar)
`endif
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
// Instances: u_dut_a (DEPTH=64, WAIT_CYCLES=2), u_dut_b (DEPTH=16, WAIT_CYCLES=0).
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        a_rd, a_wr;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_ready, a_err;

    logic        b_rd, b_wr;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_ready, b_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .mem_rd   (a_rd),
        .mem_wr   (a_wr),
        .addr     (a_addr),
        .wr_data  (a_wdata),
        .rd_data  (a_rdata),
        .ready    (a_ready),
        .addr_err (a_err)
    );

    dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .mem_rd   (b_rd),
        .mem_wr   (b_wr),
        .addr     (b_addr),
        .wr_data  (b_wdata),
        .rd_data  (b_rdata),
        .ready    (b_ready),
        .addr_err (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns ready latency in cycles
    // counted from the capture edge (-1 on timeout). Inputs are scrambled
    // after capture to confirm they are ignored.
    task automatic access_a(input logic rd, input logic wr, input logic [31:0] ad,
                            input logic [31:0] wd, output int lat,
                            output logic [31:0] got_rd, output logic got_err);
        a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = wd;
        lat = -1; got_rd = 'x; got_err = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (a_ready) begin
                lat = i; got_rd = a_rdata; got_err = a_err;
                break;
            end
            a_addr = $urandom; a_wdata = $urandom;
        end
        a_rd = 1'b0; a_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic access_b(input logic rd, input logic wr, input logic [31:0] ad,
                            input logic [31:0] wd, output int lat,
                            output logic [31:0] got_rd, output logic got_err);
        b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = wd;
        lat = -1; got_rd = 'x; got_err = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (b_ready) begin
                lat = i; got_rd = b_rdata; got_err = b_err;
                break;
            end
        end
        b_rd = 1'b0; b_wr = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] mdl [64];
    logic [31:0] mdl_last;

    initial begin
        int          lat;
        logic [31:0] got;
        logic        gerr;
        int          k;

        tbl[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h12,       32'h0,        32'h0,        1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h100,      32'h12345678, 32'h0,        1'b1};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h4,        32'hA5A5A5A5, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 1'b0, 32'h4,        32'h0,        32'h0,        1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'hFC,       32'hCAFEF00D, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'hFC,       32'h0,        32'hCAFEF00D, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h10,       32'h0BADF00D, 32'hCAFEF00D, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'h10,       32'h0,        32'h0BADF00D, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 32'hFFFFFFF0, 32'h0,        32'h0,        1'b1};

        reset = 1'b1;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_a_err",   32'(a_err),   32'd0);
        check("rst_a_rdata", a_rdata,      32'h0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        check("rst_b_rdata", b_rdata,      32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_a_ready", 32'(a_ready), 32'd0);

        // Directed table on the WAIT_CYCLES=2 instance
        for (int v = 0; v < 13; v++) begin
            access_a(tbl[v].rd, tbl[v].wr, tbl[v].addr, tbl[v].wdata, lat, got, gerr);
            check($sformatf("tbl%0d_lat", v),   32'(lat),  32'd3);
            check($sformatf("tbl%0d_err", v),   32'(gerr), 32'(tbl[v].exp_err));
            check($sformatf("tbl%0d_rdata", v), got,       tbl[v].exp_rdata);
        end

        // Reset during WAIT of a write: request abandoned, no strobe
        a_wr = 1'b1; a_addr = 32'h8; a_wdata = 32'h5;
        @(negedge clk);
        check("rstwait_in_wait_ready", 32'(a_ready), 32'd0);
        reset = 1'b1; a_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstwait_ready", 32'(a_ready), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("rstwait_after_ready", 32'(a_ready), 32'd0);
        access_a(1'b1, 1'b0, 32'h8, 32'h0, lat, got, gerr);
        check("rstwait_rd8_lat",   32'(lat),  32'd3);
        check("rstwait_rd8_err",   32'(gerr), 32'd0);
        check("rstwait_rd8_rdata", got,       32'h0);
        access_a(1'b1, 1'b0, 32'h10, 32'h0, lat, got, gerr);
        check("rstwait_rd10_rdata", got, 32'h0);

        // WAIT_CYCLES=0: held write requests, new item presented on each ready
        k = 0;
        b_wr = 1'b1; b_addr = 32'h0; b_wdata = 32'h1000_0001;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_n%0d", n), 32'(b_ready), 32'(n % 2));
            if (b_ready) begin
                k++;
                if (k < 4) begin
                    b_addr  = 32'(4 * k);
                    b_wdata = 32'h1000_0001 + 32'(k);
                end else begin
                    b_wr = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("b2b_served", 32'(k), 32'd4);
        check("b2b_quiet",  32'(b_ready), 32'd0);
        for (int w = 0; w < 4; w++) begin
            access_b(1'b1, 1'b0, 32'(4 * w), 32'h0, lat, got, gerr);
            check($sformatf("b_rd%0d_lat", w),   32'(lat),  32'd1);
            check($sformatf("b_rd%0d_rdata", w), got,       32'h1000_0001 + 32'(w));
        end
        access_b(1'b1, 1'b0, 32'h40, 32'h0, lat, got, gerr);
        check("b_oob_err",   32'(gerr), 32'd1);
        check("b_oob_rdata", got,       32'h0);
        access_b(1'b1, 1'b0, 32'h3C, 32'h0, lat, got, gerr);
        check("b_last_err",   32'(gerr), 32'd0);
        check("b_last_rdata", got,       32'h0);

        // Random traffic on instance A against a plain array model
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        mdl_last = '0;
        for (int t = 0; t < 150; t++) begin
            int          sel;
            logic        rd, wr, err;
            logic [31:0] ad, wd, exp;
            sel = $urandom_range(0, 9);
            rd  = 1'($urandom_range(0, 1));
            wr  = !rd;
            wd  = $urandom;
            ad  = 32'($urandom_range(0, 63)) * 4;
            if (sel == 7) ad = ad + 32'($urandom_range(1, 3));
            if (sel == 8) ad = 32'd256 + 32'($urandom_range(0, 4000)) * 4;
            if (sel == 9) begin rd = 1'b1; wr = 1'b1; end

            err = (ad % 4 != 0) || (ad >= 32'd256) || (rd && wr);
            if (err) begin
                exp = '0;
                mdl_last = '0;
            end else if (wr) begin
                mdl[ad / 4] = wd;
                exp = mdl_last;
            end else begin
                exp = mdl[ad / 4];
                mdl_last = exp;
            end

            access_a(rd, wr, ad, wd, lat, got, gerr);
            check($sformatf("rnd%0d_lat", t),   32'(lat),  32'd3);
            check($sformatf("rnd%0d_err", t),   32'(gerr), 32'(err));
            check($sformatf("rnd%0d_rdata", t), got,       exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words stored (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between request capture and response (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_rd  input  1  read request, held by requester until ready.
REQ-006 mem_wr  input  1  write request, held by requester until ready.
REQ-007 addr  input  32  byte address of the access.
REQ-008 wr_data  input  32  write data.
REQ-009 rd_data  output  32  read data, valid when ready=1 for a read.
REQ-010 ready  output  1  one-cycle response strobe completing the current request.
REQ-011 addr_err  output  1  qualifies ready; high marks a rejected request.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, RESP.
REQ-013 In IDLE, a request (mem_rd or mem_wr high) SHALL be captured: addr, wr_data and op latched, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-014 WAIT SHALL count WAIT_CYCLES cycles in a 4-bit counter, then go to RESP; total latency from capture edge to ready SHALL be WAIT_CYCLES+1 cycles.
REQ-015 Input changes after capture SHALL be ignored until the next IDLE.
REQ-016 RESP SHALL assert ready for exactly one cycle and return to IDLE; ready SHALL be low in all other states.
REQ-017 After RESP, IDLE SHALL last at least one cycle before the next capture (one-cycle bubble), so a request still held high during RESP is not double-served.
REQ-018 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-019 Error when addr[1:0]!=0, addr>=4*DEPTH, or mem_rd and mem_wr both high at capture: addr_err=1 with ready, no array write, rd_data driven 0.
REQ-020 Valid write SHALL update the array on the RESP clock edge; rd_data unchanged.
REQ-021 Valid read SHALL drive the addressed word on rd_data in the RESP cycle; rd_data SHALL hold that value until the next read response or error.
REQ-022 Read of a word written by the immediately preceding request SHALL return the new value.

Reset
REQ-023 On reset: state IDLE, counter 0, ready 0, addr_err 0, rd_data 0, all array words 0.
REQ-024 Reset during WAIT or RESP SHALL abandon the request with no array write and no ready pulse.

Configuration
REQ-025 Macro DMEM_PARITY_EN SHALL, when defined, add output parity_err (1 bit), store one even-parity bit per word on write, and check it on read.
REQ-026 With DMEM_PARITY_EN, parity_err SHALL pulse with ready on a read whose stored parity mismatches; data still returned; reset clears parity bits to 0.
REQ-027 Without DMEM_PARITY_EN, parity_err and parity storage SHALL not exist.

Structure
REQ-028 Package dmem_pkg SHALL hold the state enum (IDLE, WAIT, RESP), data width 32 and the default DEPTH/WAIT_CYCLES constants.
REQ-029 Storage SHALL be a sub-module dmem_array (synchronous-write, combinational-read word array with reset clear); FSM, decode and error logic stay in dmem_responder.

Verification
REQ-030 Write 0xDEADBEEF to addr 0x10, then read 0x10 -> ready 3 cycles after each capture (WAIT_CYCLES=2), rd_data=0xDEADBEEF, addr_err=0.
REQ-031 Read addr 0x12 -> ready with addr_err=1, rd_data=0; subsequent read of 0x10 still 0xDEADBEEF.
REQ-032 Write to addr 0x100 (DEPTH=64) -> addr_err=1; read 0x0 afterwards returns 0 (no aliasing).
REQ-033 mem_rd and mem_wr both high at addr 0x4 -> addr_err=1, word 1 unchanged.
REQ-034 Assert reset in WAIT of a write 0x5 to addr 0x8 -> no ready pulse; read 0x8 returns 0.
REQ-035 WAIT_CYCLES=0, back-to-back held requests -> ready every second cycle, each request served exactly once.
